// File: rtl/bank_addr_gen_pkg.sv
// bank_addr_gen_pkg: shared widths, FSM encoding and butterfly address helper for bank_addr_gen.
`ifndef BANK_ADDR_GEN_DEFS
`define BANK_ADDR_GEN_DEFS
`define ADDR_WIDTH 10
`define DATA_WIDTH 32
`define DEPTH 1024
`endif

package bank_addr_gen_pkg;
    localparam int AW = `ADDR_WIDTH;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
    // Insert a zero at bit s of j to get i0; the bottom operand sets that bit.
    function automatic logic [AW-1:0] bfly_addr(input logic [AW-1:0] j, input int s, input logic half);
        logic [AW-1:0] m;
        m = (AW'(1) << s) - AW'(1);
        return ((j & ~m) << 1) | (j & m) | (half ? (AW'(1) << s) : '0);
    endfunction
endpackage

// File: rtl/bank_addr_gen_if.sv
// bank_addr_gen_if: control/bank signals between the NTT address sequencer and its bank/RBFU.
interface bank_addr_gen_if #(parameter int LOGN = `ADDR_WIDTH);
    logic                      start, hold, busy, done, EN, REN, rd_vld, rd_sel, WEN;
    logic [`ADDR_WIDTH-1:0]    raddr, waddr;
    logic [LOGN-2:0]           tw_idx;
    logic [$clog2(LOGN)-1:0]   stage;
    modport master (input start, hold,
                    output busy, done, EN, REN, raddr, rd_vld, rd_sel, tw_idx, WEN, waddr, stage);
    modport slave  (output start, hold,
                    input busy, done, EN, REN, raddr, rd_vld, rd_sel, tw_idx, WEN, waddr, stage);
endinterface

// File: rtl/bank_addr_gen_wb_delay_line.sv
// wb_delay_line: fixed-depth shift register of {valid, data} with async reset.
module wb_delay_line #(
    parameter int STAGES = 2,
    parameter int W      = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_vld,
    input  logic [W-1:0] i_data,
    output logic         o_vld,
    output logic [W-1:0] o_data
);
    logic [STAGES-1:0] r_vld;
    logic [W-1:0]      r_data [STAGES];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_vld <= '0;
            for (int k = 0; k < STAGES; k++) r_data[k] <= '0;
        end else begin
            r_vld[0]  <= i_vld;
            r_data[0] <= i_data;
            for (int k = 1; k < STAGES; k++) begin
                r_vld[k]  <= r_vld[k-1];
                r_data[k] <= r_data[k-1];
            end
        end

    assign o_vld  = r_vld[STAGES-1];
    assign o_data = r_data[STAGES-1];
endmodule

// File: rtl/bank_addr_gen.sv
// bank_addr_gen: stage-by-stage in-place radix-2 NTT read/write address sequencer for one bank.
module bank_addr_gen
    import bank_addr_gen_pkg::*;
#(
    parameter int LOGN = `ADDR_WIDTH,
    parameter int LAT  = 4
) (
    input logic             clk,
    input logic             rst,
    bank_addr_gen_if.master bus
);
    localparam int JW = LOGN - 1;
    localparam int SW = $clog2(LOGN);
    localparam int CW = $clog2(LAT + 1);

    state_t          r_state, w_state_nxt;
    logic [JW-1:0]   r_j, w_j_nxt, w_jm, w_tw, r_tw_idx;
    logic            r_half, w_half_nxt, r_rd_vld, r_rd_sel, w_ren;
    logic [SW-1:0]   r_stage, w_stage_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [AW-1:0]   w_addr, w_raddr;

    assign w_ren   = (r_state == S_READ) && !bus.hold;
    assign w_addr  = bfly_addr(AW'(r_j), int'(r_stage), r_half);
    assign w_raddr = w_ren ? w_addr : '0;
    assign w_jm    = r_j & ((JW'(1) << r_stage) - JW'(1));
    assign w_tw    = w_jm << (JW - int'(r_stage));

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state  <= S_IDLE;
            r_j      <= '0;
            r_half   <= 1'b0;
            r_stage  <= '0;
            r_cnt    <= '0;
            r_rd_vld <= 1'b0;
            r_rd_sel <= 1'b0;
            r_tw_idx <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_j      <= w_j_nxt;
            r_half   <= w_half_nxt;
            r_stage  <= w_stage_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rd_vld <= w_ren;
            r_rd_sel <= w_ren & r_half;
            r_tw_idx <= w_ren ? w_tw : '0;
        end

    always_comb begin
        w_state_nxt = r_state;
        w_j_nxt     = r_j;
        w_half_nxt  = r_half;
        w_stage_nxt = r_stage;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: if (bus.start) begin
                w_state_nxt = S_READ;
                w_j_nxt     = '0;
                w_half_nxt  = 1'b0;
                w_stage_nxt = '0;
                w_cnt_nxt   = '0;
            end
            S_READ: if (!bus.hold) begin
                w_half_nxt = ~r_half;
                w_j_nxt    = r_half ? r_j + JW'(1) : r_j;
                w_state_nxt = (r_half && &r_j) ? S_DRAIN : S_READ;
            end
            S_DRAIN: begin
                // LAT+1 cycles lets the stage's final write retire before the next read
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CW'(LAT)) begin
                    w_cnt_nxt   = '0;
                    w_j_nxt     = '0;
                    w_half_nxt  = 1'b0;
                    w_state_nxt = (r_stage == SW'(LOGN - 1)) ? S_DONE : S_READ;
                    w_stage_nxt = (r_stage == SW'(LOGN - 1)) ? r_stage : r_stage + SW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    wb_delay_line #(.STAGES(LAT + 1), .W(AW)) u_wb (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (w_ren),
        .i_data (w_raddr),
        .o_vld  (bus.WEN),
        .o_data (bus.waddr)
    );

    assign bus.REN    = w_ren;
    assign bus.raddr  = w_raddr;
    assign bus.busy   = (r_state == S_READ) || (r_state == S_DRAIN);
    assign bus.EN     = bus.busy;
    assign bus.done   = (r_state == S_DONE);
    assign bus.rd_vld = r_rd_vld;
    assign bus.rd_sel = r_rd_sel;
    assign bus.tw_idx = r_tw_idx;
    assign bus.stage  = r_stage;
endmodule

// File: doc/bank_addr_gen.md
Name: bank_addr_gen

Overview:
- Upstream address/control sequencer for one single-port-read, single-port-write data bank.
- Walks an in-place radix-2 NTT of N=2^LOGN coefficients held in that bank, stage by stage.
- For each butterfly it issues two reads (top operand, then bottom operand) and tags each with a select and a twiddle index for the RBFU.
- It replays the same addresses as bank writes after a fixed RBFU latency, and drains between stages so no read overtakes a pending write.

Parameters:
- LOGN, default `ADDR_WIDTH: log2 of transform length. Must satisfy 2 <= LOGN <= `ADDR_WIDTH.
- LAT, default 4: cycles from rd_vld of an operand to its result being ready at the bank write port (RBFU pipeline depth). Must be >= 1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a full transform. Ignored while busy.
- hold  in  1  when high in READ, no read is issued this cycle and a bubble enters the write pipe.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last write of the last stage has retired.
- EN  out  1  bank enable; equals busy.
- REN  out  1  bank read enable.
- raddr  out  `ADDR_WIDTH  bank read address.
- rd_vld  out  1  rdata from the bank is valid this cycle; REN delayed by 1.
- rd_sel  out  1  0 = top operand, 1 = bottom operand; aligned with rd_vld.
- tw_idx  out  LOGN-1  twiddle ROM index; aligned with rd_vld.
- WEN  out  1  bank write enable.
- waddr  out  `ADDR_WIDTH  bank write address.
- stage  out  $clog2(LOGN)  current stage, for debug and twiddle bank selection.

Behaviour:
- Reset values: state=IDLE; busy, done, EN, REN, rd_vld, rd_sel, WEN = 0; raddr, waddr, tw_idx, stage = 0; write pipe all invalid.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: on start go to READ with stage=0, j=0, half=0.
- READ:
  - Each cycle with hold=0, assert REN for one operand, then toggle half.
  - When half returns to 0, increment j.
  - Butterfly index j runs 0..N/2-1.
  - After the bottom read of j=N/2-1, go to DRAIN.
- Address rule, stage s:
  - i0 = {j[LOGN-2:s], 1'b0, j[s-1:0]}; i1 = i0 | (1<<s).
  - Top operand reads i0; bottom operand reads i1. Upper address bits above LOGN are 0.
  - tw_idx = j[s-1:0] << (LOGN-1-s), so it is 0 for stage 0.
- Read timing: raddr and REN are registered and presented in the cycle the read is issued. rd_vld, rd_sel and tw_idx appear one cycle later, matching bank read latency.
- Write pipe:
  - A shift register of depth LAT+1 carries {valid, addr}.
  - An address issued on raddr at cycle t appears on waddr with WEN=1 at cycle t+1+LAT.
  - hold cycles and non-READ cycles insert invalid entries.
- DRAIN:
  - Count LAT+1 cycles after the last read so the final write retires before the next read.
  - Then, if stage<LOGN-1: stage++, j=0, return to READ. Otherwise go to DONE.
- DONE: done=1 for exactly one cycle, busy drops in the same cycle, next state IDLE.
- Simultaneous read and write in one cycle is legal; the addresses differ by construction within a stage.
- hold=1 in any non-READ state has no effect. hold does not stall the write pipe.
- start while busy is ignored, including in the DONE cycle.
- Async rst mid-transform:
  - Returns everything to reset values immediately and discards all in-flight writes.
  - WEN must be 0 in the first cycle after release.
- Throughput with no hold: LOGN*(N+LAT+1) cycles from the first READ cycle to the cycle before DONE.

Decomposition:
- Shared package/header (parameter.v) holds:
  - FSM state encodings: localparams S_IDLE, S_READ, S_DRAIN, S_DONE.
  - The `ADDR_WIDTH / `DATA_WIDTH / `DEPTH defines already in use.
- One natural sub-module: wb_delay_line, a parameterized depth × width shift register with a valid bit and async reset. It is reusable for aligning twiddles elsewhere.

Test Plan:
- LOGN=3, LAT=2, start pulse:
  - Stage 1 raddr sequence 0,2,1,3,4,6,5,7 with tw_idx 0,0,2,2,0,0,2,2.
  - Stage 0 sequence 0,1,2,3,4,5,6,7. Stage 2 sequence 0,4,1,5,2,6,3,7.
- Same config: each waddr equals the raddr issued 3 cycles earlier, with WEN aligned. done is asserted 33 cycles after the first REN.
- Stage boundary: the gap between the stage's last REN and the next stage's first REN is exactly LAT+2=4 cycles. No raddr equals a pending waddr.
- hold high for 3 cycles mid-stage 1:
  - raddr sequence is frozen, with no REN during those cycles.
  - 3 WEN bubbles appear 3 cycles later.
  - Total time grows by 3 cycles.
- rst asserted during stage 1 with writes in flight:
  - All outputs go to 0 immediately; no WEN after release.
  - A fresh start produces the full stage 0 sequence.
- start pulsed while busy and in the DONE cycle: ignored. Exactly one done pulse; busy=0 afterward.
